// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared state and owner encodings for the memory port arbiter
package mem_port_arbiter_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;
    typedef enum logic {OWN_IF = 1'b0, OWN_LS = 1'b1} owner_t;
endpackage

// File: rtl/mem_port_arbiter_prio.sv
// mem_arb_prio: LS-over-IF winner select with a starvation guard on consecutive LS grants
module mem_arb_prio
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_LS_BURST = 2
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   arb_en,
    input  logic   if_req,
    input  logic   ls_req,
    output owner_t winner
);
    localparam int SW = $clog2(MAX_LS_BURST + 1);
    logic [SW-1:0] ls_streak;
    logic          force_if;
    assign force_if = if_req && ls_streak == SW'(MAX_LS_BURST);
    assign winner   = (ls_req && !force_if) ? OWN_LS : OWN_IF;
    // count LS wins over a waiting IF; the guard keeps it from passing MAX_LS_BURST
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ls_streak <= '0;
        else if (arb_en)
            ls_streak <= (!if_req || winner == OWN_IF) ? '0 : ls_streak + 1'b1;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares a single-port memory between instruction fetch and load/store
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 8,
    parameter int MEM_LAT      = 2,
    parameter int MAX_LS_BURST = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_done,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int LW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
    state_t            state, state_nx;
    owner_t            owner, winner;
    logic [LW-1:0]     lat_cnt;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_we, grant, busy, last;
    assign grant = state == IDLE && (if_req || ls_req);
    assign busy  = state == BUSY;
    assign last  = busy && lat_cnt == '0;
    mem_arb_prio #(.MAX_LS_BURST(MAX_LS_BURST)) u_prio (
        .clk    (clk),
        .rst_n  (rst_n),
        .arb_en (state == IDLE),
        .if_req (if_req),
        .ls_req (ls_req),
        .winner (winner)
    );
    // next state: one access per grant, then a single response cycle
    always_comb begin
        state_nx = state == IDLE ? (grant ? BUSY : IDLE) :
                   state == BUSY ? (last ? RESP : BUSY) : IDLE;
    end
    // state register; reset abandons any transaction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end
    // latch the winner's request at grant so later input changes are ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner   <= OWN_IF;
            a_addr  <= '0;
            a_we    <= 1'b0;
            a_wdata <= '0;
            lat_cnt <= '0;
        end else if (grant) begin
            owner   <= winner;
            a_addr  <= winner == OWN_LS ? ls_addr : if_addr;
            a_we    <= winner == OWN_LS && ls_we;
            a_wdata <= winner == OWN_LS ? ls_wdata : '0;
            lat_cnt <= LW'(MEM_LAT - 1);
        end else if (busy && !last) begin
            lat_cnt <= lat_cnt - 1'b1;
        end
    end
    // capture read data into the owner's register on the last access cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rdata <= '0;
            ls_rdata <= '0;
        end else if (last && !a_we) begin
            if (owner == OWN_IF)
                if_rdata <= mem_rdata;
            else
                ls_rdata <= mem_rdata;
        end
    end
    // outputs decode straight from state so reset clears them without waiting for an edge
    always_comb begin
        if_gnt    = state != IDLE && owner == OWN_IF;
        ls_gnt    = state != IDLE && owner == OWN_LS;
        if_done   = state == RESP && owner == OWN_IF;
        ls_done   = state == RESP && owner == OWN_LS;
        mem_en    = busy;
        mem_we    = busy && a_we;
        mem_addr  = busy ? a_addr : '0;
        mem_wdata = busy ? a_wdata : '0;
    end
endmodule
